// File: rtl/bcrypt_pstore_mb_if.sv
// rtl/bcrypt_pstore_mb_if.sv - Port bundle between the bcrypt input/core side and the P/data store
interface bcrypt_pstore_mb_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic [WIDTH-1:0]  din;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_wr_en;
  logic              ld_commit;
  logic              ld_ready;
  logic [ADDR_W-1:0] PD_addr;
  logic [WIDTH-1:0]  PD_out;
  logic              bank_valid;
  logic              bank_release;
  logic [ADDR_W-1:0] PN_wr_addr;
  logic [ADDR_W-1:0] PN_addr;
  logic              PN_wr_en;
  logic [WIDTH-1:0]  Ltmp_in;
  logic              sel_din;
  logic              decr;
  logic [WIDTH-1:0]  PN_out;
  logic [WIDTH-1:0]  S_input;
  logic              ZF_wr_en;
  logic              ZF;
  logic              copy_start;
  logic              copy_busy;
  logic              copy_done;

  modport master (
    output din, ld_addr, ld_wr_en, ld_commit, PD_addr, bank_release,
           PN_wr_addr, PN_addr, PN_wr_en, Ltmp_in, sel_din, decr, ZF_wr_en, copy_start,
    input  ld_ready, PD_out, bank_valid, PN_out, S_input, ZF, copy_busy, copy_done
  );

  modport slave (
    input  din, ld_addr, ld_wr_en, ld_commit, PD_addr, bank_release,
           PN_wr_addr, PN_addr, PN_wr_en, Ltmp_in, sel_din, decr, ZF_wr_en, copy_start,
    output ld_ready, PD_out, bank_valid, PN_out, S_input, ZF, copy_busy, copy_done
  );
endinterface

// File: rtl/bcrypt_pstore_mb.sv
// rtl/bcrypt_pstore_mb.sv - Multi-bank key/data store, working P RAM with decrement/ZF, key copy sequencer
module bcrypt_pstore_mb #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int NBANKS   = 2,
  parameter int CNT_W    = 6,
  parameter int COPY_LEN = 18
) (
  input  logic              CLK,
  input  logic              RESET,
  bcrypt_pstore_mb_if.slave bus
);
  localparam int DEPTH  = 2**ADDR_W;
  localparam int PTR_W  = (NBANKS > 1) ? $clog2(NBANKS) : 1;
  localparam int CNTB_W = $clog2(NBANKS + 1);
  localparam logic [PTR_W-1:0]  LAST_BANK = PTR_W'(NBANKS - 1);
  localparam logic [CNTB_W-1:0] FULL      = CNTB_W'(NBANKS);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(COPY_LEN - 1);

  typedef enum logic {IDLE, COPY} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic              copy_done_q;
  logic              zf_q;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNTB_W-1:0] count_q, count_d;

  logic [WIDTH-1:0] bank_mem [NBANKS][DEPTH];
  logic [WIDTH-1:0] pn_mem [DEPTH];

  logic              full, busy, do_commit, do_release;
  logic [ADDR_W-1:0] pd_idx;
  logic [WIDTH-1:0]  pn_rd, src, mux;
  logic [CNT_W-1:0]  low_src, low;

  assign full       = (count_q == FULL);
  assign busy       = (state_q == COPY);
  assign do_commit  = bus.ld_commit && !full;
  // A release mid-copy would switch the bank under the sequencer, so it is held off.
  assign do_release = bus.bank_release && (count_q != '0) && !busy;

  assign bus.ld_ready   = !full;
  assign bus.bank_valid = (count_q != '0);
  assign bus.copy_busy  = busy;
  assign bus.copy_done  = copy_done_q;
  assign bus.ZF         = zf_q;

  assign pd_idx     = busy ? idx_q : bus.PD_addr;
  assign bus.PD_out = bank_mem[rd_ptr_q][pd_idx];
  assign pn_rd      = pn_mem[bus.PN_addr];
  assign bus.PN_out = pn_rd;

  // Only the counter field takes the decrement; upper bits always come from din/Ltmp_in.
  assign src         = bus.sel_din ? bus.din : bus.Ltmp_in;
  assign low_src     = bus.decr ? pn_rd[CNT_W-1:0] : src[CNT_W-1:0];
  assign low         = low_src - CNT_W'(bus.decr);
  assign mux         = {src[WIDTH-1:CNT_W], low};
  assign bus.S_input = mux;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_commit) wr_ptr_d = (wr_ptr_q == LAST_BANK) ? '0 : wr_ptr_q + PTR_W'(1);
    if (do_release) rd_ptr_d = (rd_ptr_q == LAST_BANK) ? '0 : rd_ptr_q + PTR_W'(1);
    if (do_commit && !do_release) count_d = count_q + CNTB_W'(1);
    else if (!do_commit && do_release) count_d = count_q - CNTB_W'(1);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      zf_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (bus.ZF_wr_en) zf_q <= (low == '0);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      copy_done_q <= 1'b0;
    end else begin
      copy_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.copy_start && (count_q != '0)) begin
            state_q <= COPY;
            idx_q   <= '0;
          end
        end
        COPY: begin
          if (idx_q == LAST_IDX) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            copy_done_q <= 1'b1;
          end else begin
            idx_q <= idx_q + ADDR_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage arrays carry no reset; the copy owns the PN write port while busy.
  always_ff @(posedge CLK) begin
    if (bus.ld_wr_en && !full) bank_mem[wr_ptr_q][bus.ld_addr] <= bus.din;
    if (busy) pn_mem[idx_q] <= bank_mem[rd_ptr_q][idx_q];
    else if (bus.PN_wr_en) pn_mem[bus.PN_wr_addr] <= mux;
  end
endmodule

// File: tb/tb_bcrypt_pstore_mb.sv
// tb/tb_bcrypt_pstore_mb.sv - Self-checking bench for bcrypt_pstore_mb
module tb_bcrypt_pstore_mb;
  localparam int WIDTH = 32, ADDR_W = 5, NBANKS = 2, CNT_W = 6, COPY_LEN = 18, DEPTH = 32;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  bcrypt_pstore_mb_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  bcrypt_pstore_mb #(
    .WIDTH(WIDTH), .ADDR_W(ADDR_W), .NBANKS(NBANKS), .CNT_W(CNT_W), .COPY_LEN(COPY_LEN)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus)
  );

  int nvec = 0;
  int nmis = 0;

  logic [31:0] bm [NBANKS][DEPTH];
  logic [31:0] pm [DEPTH];
  int m_rd, m_cnt, m_cidx;
  logic m_copy, m_done, m_zf;

  typedef struct {
    logic        sel;
    logic        decr;
    logic        wr;
    logic [31:0] din;
    logic [31:0] ltmp;
    logic [31:0] exp_s;
    logic        exp_zf;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic m_reset();
    m_rd = 0; m_cnt = 0; m_cidx = 0;
    m_copy = 1'b0; m_done = 1'b0; m_zf = 1'b0;
  endtask

  function automatic logic [31:0] m_mux();
    logic [31:0] s;
    logic [5:0]  l;
    s = bus.sel_din ? bus.din : bus.Ltmp_in;
    l = bus.decr ? pm[bus.PN_addr][5:0] : s[5:0];
    l = l - (bus.decr ? 6'd1 : 6'd0);
    return (s & 32'hFFFF_FFC0) | {26'd0, l};
  endfunction

  task automatic model_edge();
    logic [31:0] s;
    int wr;
    int comm, rel;
    if (RESET) begin
      m_reset();
      return;
    end
    s  = m_mux();
    wr = (m_rd + m_cnt) % NBANKS;
    if (bus.ld_wr_en && m_cnt < NBANKS) bm[wr][bus.ld_addr] = bus.din;
    if (m_copy) pm[m_cidx] = bm[m_rd][m_cidx];
    else if (bus.PN_wr_en) pm[bus.PN_wr_addr] = s;
    if (bus.ZF_wr_en) m_zf = (s[5:0] == 6'd0);
    comm = (bus.ld_commit && m_cnt < NBANKS) ? 1 : 0;
    rel  = (bus.bank_release && m_cnt > 0 && !m_copy) ? 1 : 0;
    m_done = 1'b0;
    if (m_copy) begin
      if (m_cidx == COPY_LEN - 1) begin
        m_copy = 1'b0;
        m_done = 1'b1;
      end else begin
        m_cidx++;
      end
    end else if (bus.copy_start && m_cnt > 0) begin
      m_copy = 1'b1;
      m_cidx = 0;
    end
    if (rel != 0) m_rd = (m_rd + 1) % NBANKS;
    m_cnt = m_cnt + comm - rel;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.din = '0; bus.ld_addr = '0; bus.ld_wr_en = 0; bus.ld_commit = 0;
    bus.PD_addr = '0; bus.bank_release = 0; bus.PN_wr_addr = '0; bus.PN_addr = '0;
    bus.PN_wr_en = 0; bus.Ltmp_in = '0; bus.sel_din = 0; bus.decr = 0;
    bus.ZF_wr_en = 0; bus.copy_start = 0;
  endtask

  task automatic pn_write(input logic [4:0] a, input logic [31:0] d);
    bus.sel_din = 1; bus.decr = 0; bus.din = d; bus.PN_wr_addr = a; bus.PN_wr_en = 1;
    cycle();
    bus.PN_wr_en = 0;
  endtask

  task automatic fill_bank(input logic [31:0] base);
    for (int i = 0; i < DEPTH; i++) begin
      bus.ld_wr_en = 1; bus.ld_addr = 5'(i); bus.din = base + 32'(i);
      cycle();
    end
    bus.ld_wr_en = 0;
  endtask

  task automatic check_all();
    int a;
    a = m_copy ? m_cidx : int'(bus.PD_addr);
    chkb("ld_ready", bus.ld_ready, m_cnt < NBANKS);
    chkb("bank_valid", bus.bank_valid, m_cnt > 0);
    chkb("copy_busy", bus.copy_busy, m_copy);
    chkb("copy_done", bus.copy_done, m_done);
    chkb("zf", bus.ZF, m_zf);
    chk("pd_out", bus.PD_out, bm[m_rd][a]);
    chk("pn_out", bus.PN_out, pm[bus.PN_addr]);
    chk("s_input", bus.S_input, m_mux());
  endtask

  initial begin
    int busy_n, done_n;
    logic [31:0] dec_exp [4];
    logic        zf_exp [4];

    tbl[0] = '{1'b0, 1'b0, 1'b1, 32'hAAAA5555, 32'hDEADBEC0, 32'hDEADBEC0, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 32'hAAAA5555, 32'hDEADBEC0, 32'hAAAA5555, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 32'hAAAA5555, 32'hDEADBEC0, 32'hAAAA5542, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 32'hAAAA5555, 32'hDEADBEC0, 32'hDEADBEC2, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 32'h00000040, 32'h12345678, 32'h00000040, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    dec_exp = '{32'd2, 32'd1, 32'd0, 32'h3F};
    zf_exp  = '{1'b0, 1'b0, 1'b1, 1'b0};

    idle_inputs();
    m_reset();
    RESET = 1;
    cycle();
    cycle();
    RESET = 0;
    #1;
    chkb("rst_ld_ready", bus.ld_ready, 1'b1);
    chkb("rst_bank_valid", bus.bank_valid, 1'b0);
    chkb("rst_copy_busy", bus.copy_busy, 1'b0);
    chkb("rst_copy_done", bus.copy_done, 1'b0);
    chkb("rst_zf", bus.ZF, 1'b0);

    bus.copy_start = 1;
    cycle();
    bus.copy_start = 0;
    chkb("copy_no_bank", bus.copy_busy, 1'b0);

    fill_bank(32'h1000);
    bus.ld_commit = 1;
    #1;
    chkb("valid_before_commit", bus.bank_valid, 1'b0);
    cycle();
    bus.ld_commit = 0; bus.PD_addr = 5'd5;
    #1;
    chkb("valid_after_commit", bus.bank_valid, 1'b1);
    chk("pd_bank0_5", bus.PD_out, 32'h1005);
    chkb("ready_one_bank", bus.ld_ready, 1'b1);

    pn_write(5'd18, 32'h55555555);
    bus.copy_start = 1;
    cycle();
    bus.copy_start = 0;
    busy_n = 0; done_n = 0;
    for (int c = 1; c <= 30; c++) begin
      bus.PN_wr_en = (c == 4); bus.PN_wr_addr = 5'd18; bus.sel_din = 1; bus.din = 32'hBAD0BAD0;
      #1;
      chkb("copy_busy_window", bus.copy_busy, c <= COPY_LEN);
      chkb("copy_done_cycle", bus.copy_done, c == COPY_LEN + 1);
      if (c <= COPY_LEN) chk("copy_pd_idx", bus.PD_out, 32'h1000 + 32'(c - 1));
      if (bus.copy_busy) busy_n++;
      if (bus.copy_done) done_n++;
      cycle();
    end
    bus.PN_wr_en = 0;
    chk("copy_busy_len", 32'(busy_n), 32'(COPY_LEN));
    chk("copy_done_pulses", 32'(done_n), 32'd1);
    for (int i = 0; i <= COPY_LEN; i++) begin
      bus.PN_addr = 5'(i);
      #1;
      chk("copy_pn_word", bus.PN_out, (i < COPY_LEN) ? 32'h1000 + 32'(i) : 32'h55555555);
    end

    pn_write(5'd18, 32'd3);
    bus.decr = 1; bus.sel_din = 1; bus.din = '0; bus.PN_addr = 5'd18; bus.PN_wr_addr = 5'd18;
    bus.PN_wr_en = 1; bus.ZF_wr_en = 1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("decr_value", bus.PN_out, dec_exp[k]);
      chkb("decr_zf", bus.ZF, zf_exp[k]);
    end
    idle_inputs();

    pn_write(5'd20, 32'h12345603);
    for (int r = 0; r < 6; r++) begin
      bus.PN_addr = 5'd20; bus.PN_wr_addr = 5'd21; bus.PN_wr_en = tbl[r].wr; bus.ZF_wr_en = 1;
      bus.sel_din = tbl[r].sel; bus.decr = tbl[r].decr; bus.din = tbl[r].din; bus.Ltmp_in = tbl[r].ltmp;
      #1;
      chk("tbl_s_input", bus.S_input, tbl[r].exp_s);
      cycle();
      bus.PN_wr_en = 0; bus.ZF_wr_en = 0;
      chkb("tbl_zf", bus.ZF, tbl[r].exp_zf);
      if (tbl[r].wr) begin
        bus.PN_addr = 5'd21;
        #1;
        chk("tbl_pn_write", bus.PN_out, tbl[r].exp_s);
      end
    end
    idle_inputs();

    fill_bank(32'h2000);
    bus.ld_commit = 1;
    cycle();
    bus.ld_commit = 0; bus.PD_addr = 5'd5;
    #1;
    chkb("full_ready", bus.ld_ready, 1'b0);
    bus.ld_wr_en = 1; bus.ld_addr = 5'd5; bus.din = 32'h0BAD; bus.ld_commit = 1;
    cycle();
    bus.ld_wr_en = 0; bus.ld_commit = 0;
    chkb("full_ignored_ready", bus.ld_ready, 1'b0);
    chk("full_pd_bank0", bus.PD_out, 32'h1005);
    bus.bank_release = 1;
    cycle();
    bus.bank_release = 0;
    chkb("release_ready", bus.ld_ready, 1'b1);
    chk("release_pd_bank1", bus.PD_out, 32'h2005);
    bus.ld_wr_en = 1; bus.ld_addr = 5'd6; bus.din = 32'h3006;
    cycle();
    bus.ld_wr_en = 0; bus.ld_commit = 1; bus.bank_release = 1;
    cycle();
    bus.ld_commit = 0; bus.bank_release = 0;
    chkb("both_valid", bus.bank_valid, 1'b1);
    chkb("both_ready", bus.ld_ready, 1'b1);
    chk("both_pd5_not_overwritten", bus.PD_out, 32'h1005);
    bus.PD_addr = 5'd6;
    #1;
    chk("both_pd6", bus.PD_out, 32'h3006);

    bus.copy_start = 1;
    cycle();
    bus.copy_start = 0;
    for (int c = 1; c < 7; c++) cycle();
    chkb("mid_copy_busy", bus.copy_busy, 1'b1);
    RESET = 1;
    m_reset();
    #1;
    chkb("abort_busy", bus.copy_busy, 1'b0);
    chkb("abort_valid", bus.bank_valid, 1'b0);
    chkb("abort_ready", bus.ld_ready, 1'b1);
    cycle();
    RESET = 0;
    for (int c = 0; c < 25; c++) begin
      #1;
      chkb("abort_no_done", bus.copy_done, 1'b0);
      cycle();
    end

    for (int i = 0; i < DEPTH; i++) pn_write(5'(i), $urandom);
    for (int n = 0; n < 400; n++) begin
      bus.ld_wr_en = 1'($urandom_range(0, 1));
      bus.ld_addr = 5'($urandom);
      bus.din = $urandom;
      if ($urandom_range(0, 3) == 0) bus.din[5:0] = 6'd0;
      bus.ld_commit = ($urandom_range(0, 5) == 0);
      bus.bank_release = ($urandom_range(0, 4) == 0);
      bus.PD_addr = 5'($urandom);
      bus.PN_wr_addr = 5'($urandom);
      bus.PN_addr = ($urandom_range(0, 2) == 0) ? bus.PN_wr_addr : 5'($urandom);
      bus.PN_wr_en = 1'($urandom_range(0, 1));
      bus.Ltmp_in = $urandom;
      if ($urandom_range(0, 3) == 0) bus.Ltmp_in[5:0] = 6'd0;
      bus.sel_din = 1'($urandom_range(0, 1));
      bus.decr = 1'($urandom_range(0, 1));
      bus.ZF_wr_en = 1'($urandom_range(0, 1));
      bus.copy_start = ($urandom_range(0, 11) == 0);
      #1;
      check_all();
      cycle();
    end
    idle_inputs();
    #1;
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/bcrypt_pstore_mb.md
# bcrypt_pstore_mb

Parametrised multi-bank P/data store for the bcrypt core. Holds NBANKS banks of per-key constant data (expanded key, iteration count, salt, IDs) loaded by the input side while the core computes from the current bank. It also provides a working RAM for the P-array and counters, with in-place decrement and a zero flag, and a hardware sequencer that copies the expanded key from the active data bank into the working RAM. It sits between the core's input buffer and the bcrypt datapath.

## Interface
- WIDTH, 32, data word width
- ADDR_W, 5, address width; every RAM is 2**ADDR_W words deep
- NBANKS, 2, number of data banks (2..8)
- CNT_W, 6, counter field width (low bits subject to decrement/ZF); CNT_W < WIDTH
- COPY_LEN, 18, words copied by the sequencer (1..2**ADDR_W)
- CLK  in  1  clock
- RESET  in  1  asynchronous, active-high reset
- din  in  WIDTH  load data
- ld_addr  in  ADDR_W  load address in the fill bank
- ld_wr_en  in  1  write din to the fill bank
- ld_commit  in  1  fill bank complete; hand it to the core
- ld_ready  out  1  a free fill bank exists
- PD_addr  in  ADDR_W  core read address, active bank
- PD_out  out  WIDTH  active-bank word (combinational read)
- bank_valid  out  1  active bank holds committed data
- bank_release  in  1  core finished with the active bank
- PN_wr_addr, PN_addr  in  ADDR_W  working RAM write/read addresses
- PN_wr_en  in  1  working RAM write
- Ltmp_in  in  WIDTH  datapath result
- sel_din, decr  in  1  input-mux controls
- PN_out  out  WIDTH  PN[PN_addr] (combinational read)
- S_input  out  WIDTH  working RAM input-mux output
- ZF_wr_en  in  1  update zero flag
- ZF  out  1  zero flag
- copy_start  in  1  start expanded-key copy
- copy_busy  out  1  copy in progress
- copy_done  out  1  one-cycle completion pulse

## Operation
- Bank ring uses wr_ptr, rd_ptr (0..NBANKS-1, wrap) and count (0..NBANKS).
- ld_ready = count < NBANKS. bank_valid = count > 0.
- ld_wr_en writes bank[wr_ptr][ld_addr]. It is ignored when count == NBANKS.
- ld_commit with count < NBANKS: wr_ptr++, count++. Otherwise it is ignored.
- bank_release with count > 0 and !copy_busy: rd_ptr++, count--. Otherwise it is ignored.
- Commit and release in the same cycle (both legal): both pointers advance and count is unchanged.
- PD_out = bank[rd_ptr][a], where a = copy index while copy_busy, else PD_addr.
- Input mux, upper bits [WIDTH-1:CNT_W]: sel_din ? din : Ltmp_in.
- Input mux, low bits [CNT_W-1:0]: (decr ? PN_out : sel_din ? din : Ltmp_in) − decr, modulo 2**CNT_W. 0 − 1 wraps to all-ones.
- S_input = mux output.
- PN_wr_en writes the mux output to PN[PN_wr_addr].
- ZF_wr_en: ZF <= (mux low bits == 0).
- Sequencer FSM, states IDLE and COPY.
  - IDLE → COPY on copy_start && bank_valid; idx <= 0.
  - copy_start in IDLE without bank_valid is ignored.
  - copy_start while in COPY is ignored.
  - In COPY, each edge: PN[idx] <= bank[rd_ptr][idx], then idx++.
  - After the edge writing idx == COPY_LEN−1: → IDLE, copy_done <= 1 for one cycle.
  - copy_busy = (state == COPY).
  - While copy_busy, PN_wr_en is dropped (the copy has priority). PN reads and ZF_wr_en still work.
- RAM contents are not reset.

## Timing
- Reset values: wr_ptr = rd_ptr = count = 0, state IDLE, idx = 0, ZF = 0, copy_done = 0. So ld_ready = 1, bank_valid = 0, copy_busy = 0.
- Reset asserted mid-copy aborts the copy immediately. Words already written stay in PN; no copy_done is produced.
- All writes, pointers and ZF update on the rising CLK edge. PD_out, PN_out and S_input are combinational from addresses.
- Load-to-core: after a commit edge, bank_valid rises in the next cycle and the bank is readable in that cycle.
- Copy: copy_start sampled at edge 0. copy_busy is high for cycles 1..COPY_LEN. Writes occur at edges 1..COPY_LEN. copy_done is high in cycle COPY_LEN+1. A new copy_start is accepted in that same cycle.
- Decrement: read, subtract and write in one cycle (PN_addr == PN_wr_addr with decr and PN_wr_en). ZF can be updated in the same cycle from the same mux value.

## Test plan
- Reset, then fill bank 0 with words 0x1000+i (i = 0..31) and commit → bank_valid = 1 next cycle; PD_out at PD_addr = 5 reads 0x1005; ld_ready = 1.
- NBANKS = 2: commit two banks → ld_ready = 0; a third ld_wr_en/commit is ignored; bank_release → ld_ready = 1, and PD_addr = 5 reads bank 1 data.
- copy_start with COPY_LEN = 18 → copy_busy high for exactly 18 cycles; PN[0..17] = 0x1000..0x1011; PN[18] untouched; copy_done single pulse; a PN_wr_en issued during the copy has no effect.
- PN[18] = 3; decrement with ZF_wr_en on 3 cycles → values 2, 1, 0 with ZF = 0, 0, 1; a fourth decrement → low 6 bits 0x3F, ZF = 0.
- sel_din = 0, Ltmp_in = 0xDEADBEC0, decr = 0, write → PN = 0xDEADBEC0, ZF_wr_en → ZF = 1 (low 6 bits zero).
- Assert RESET during cycle 7 of a copy → copy_busy = 0 and count = 0 immediately; no copy_done pulse.
